demux_1x2_buffered: RTL and testbench



---
 rtl/demux_1x2_buffered.sv | 116 +++++++++++
 tb/tb_demux_1x2_buffered.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_buffered.sv
// 1-to-2 valid/ready demultiplexer with a show-ahead FIFO per output port.
// Define DEMUX_STATS_EN to add per-port completed-pop counters (xfer1_cnt/xfer2_cnt, stats_clr).
module demux_1x2_buffered #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             port_select,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] dat1,
   output logic             dat1_valid,
   input  logic             dat1_ready,
   output logic [WIDTH-1:0] dat2,
   output logic             dat2_valid,
   input  logic             dat2_ready,
   output logic [CW-1:0]    count1,
   output logic [CW-1:0]    count2
`ifdef DEMUX_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [15:0]      xfer1_cnt,
   output logic [15:0]      xfer2_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       valid_out;
   logic [1:0]       out_ready;
   logic [CW-1:0]    count [2];
   logic [WIDTH-1:0] head  [2];

   assign out_ready = {dat2_ready, dat1_ready};

   // Acceptance depends only on the registered occupancy of the selected port.
   assign in_ready = port_select ? (count[1] < CW'(DEPTH)) : (count[0] < CW'(DEPTH));

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [WIDTH-1:0] mem_reg [DEPTH];
         logic [AW-1:0]    wr_ptr_reg;
         logic [AW-1:0]    rd_ptr_reg;
         logic [CW-1:0]    count_reg;
         logic [WIDTH-1:0] last_reg;

         assign push[gi]      = in_valid && in_ready && (port_select == 1'(gi));
         assign valid_out[gi] = (count_reg != '0);
         assign pop[gi]       = valid_out[gi] && out_ready[gi];
         assign count[gi]     = count_reg;
         // When empty, keep presenting the last word shown rather than a stale slot.
         assign head[gi]      = valid_out[gi] ? mem_reg[rd_ptr_reg] : last_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem_reg[i] <= '0;
               end
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
               last_reg   <= '0;
            end else begin
               if (push[gi]) begin
                  mem_reg[wr_ptr_reg] <= data_in;
                  wr_ptr_reg          <= wr_ptr_reg + 1'b1;
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + 1'b1;
               end
               if (valid_out[gi]) begin
                  last_reg <= mem_reg[rd_ptr_reg];
               end
               case ({push[gi], pop[gi]})
                  2'b10:   count_reg <= count_reg + 1'b1;
                  2'b01:   count_reg <= count_reg - 1'b1;
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

   assign dat1       = head[0];
   assign dat2       = head[1];
   assign dat1_valid = valid_out[0];
   assign dat2_valid = valid_out[1];
   assign count1     = count[0];
   assign count2     = count[1];

`ifdef DEMUX_STATS_EN
   logic [15:0] xfer_reg [2];

   generate
      for (gi = 0; gi < 2; gi++) begin : g_stats
         always_ff @(posedge clk) begin
            if (rst || stats_clr) begin
               xfer_reg[gi] <= '0;
            end else if (pop[gi]) begin
               xfer_reg[gi] <= xfer_reg[gi] + 16'd1;
            end
         end
      end
   endgenerate

   assign xfer1_cnt = xfer_reg[0];
   assign xfer2_cnt = xfer_reg[1];
`endif

endmodule

// File: tb/tb_demux_1x2_buffered.sv
// Bench for demux_1x2_buffered: queue-based reference model checked every cycle,
// plus directed literal checks that follow the test plan.
module tb_demux_1x2_buffered;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             port_select;
   logic [WIDTH-1:0] data_in;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dat1, dat2;
   logic             dat1_valid, dat2_valid;
   logic             dat1_ready, dat2_ready;
   logic [CW-1:0]    count1, count2;
`ifdef DEMUX_STATS_EN
   logic             stats_clr;
   logic [15:0]      xfer1_cnt, xfer2_cnt;
`endif

   int tests = 0;
   int fails = 0;

   demux_1x2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .port_select(port_select), .data_in(data_in),
      .in_valid(in_valid), .in_ready(in_ready),
      .dat1(dat1), .dat1_valid(dat1_valid), .dat1_ready(dat1_ready),
      .dat2(dat2), .dat2_valid(dat2_valid), .dat2_ready(dat2_ready),
      .count1(count1), .count2(count2)
`ifdef DEMUX_STATS_EN
      , .stats_clr(stats_clr), .xfer1_cnt(xfer1_cnt), .xfer2_cnt(xfer2_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: one queue per port, updated at each rising edge from the sampled inputs.
   logic [WIDTH-1:0] q1[$];
   logic [WIDTH-1:0] q2[$];
   logic [WIDTH-1:0] last1 = '0, last2 = '0;
   int               x1 = 0, x2 = 0;
   bit               started = 0;

   always @(posedge clk) begin
      bit do_push, p1, p2;
      if (rst) begin
         q1.delete(); q2.delete();
         last1 = '0; last2 = '0;
         x1 = 0; x2 = 0;
         started = 1;
      end else if (started) begin
         do_push = in_valid && (port_select ? (q2.size() < DEPTH) : (q1.size() < DEPTH));
         p1 = (q1.size() > 0) && dat1_ready;
         p2 = (q2.size() > 0) && dat2_ready;
         if (q1.size() > 0) last1 = q1[0];
         if (q2.size() > 0) last2 = q2[0];
         if (p1) begin void'(q1.pop_front()); x1 = (x1 + 1) % 65536; end
         if (p2) begin void'(q2.pop_front()); x2 = (x2 + 1) % 65536; end
`ifdef DEMUX_STATS_EN
         if (stats_clr) begin x1 = 0; x2 = 0; end
`endif
         if (do_push) begin
            if (port_select) q2.push_back(data_in);
            else             q1.push_back(data_in);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_in_ready", 32'(in_ready),
             32'(port_select ? (q2.size() < DEPTH) : (q1.size() < DEPTH)));
         chk("m_count1", 32'(count1), 32'(q1.size()));
         chk("m_count2", 32'(count2), 32'(q2.size()));
         chk("m_dat1_valid", 32'(dat1_valid), 32'(q1.size() > 0));
         chk("m_dat2_valid", 32'(dat2_valid), 32'(q2.size() > 0));
         chk("m_dat1", dat1, (q1.size() > 0) ? q1[0] : last1);
         chk("m_dat2", dat2, (q2.size() > 0) ? q2[0] : last2);
`ifdef DEMUX_STATS_EN
         chk("m_xfer1", 32'(xfer1_cnt), 32'(x1));
         chk("m_xfer2", 32'(xfer2_cnt), 32'(x2));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic sel, input logic [31:0] d);
      in_valid = 1'b1; port_select = sel; data_in = d;
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; port_select = 1'b0; data_in = 32'd55;
      dat1_ready = 1'b0; dat2_ready = 1'b0;
`ifdef DEMUX_STATS_EN
      stats_clr = 1'b0;
`endif
      // Reset: two edges with in_valid held high, nothing may be stored.
      cyc(); cyc();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_dat1_valid", 32'(dat1_valid), 32'd0);
      chk("rst_dat2_valid", 32'(dat2_valid), 32'd0);
      chk("rst_count1", 32'(count1), 32'd0);
      chk("rst_count2", 32'(count2), 32'd0);
      chk("rst_dat1", dat1, 32'd0);
      chk("rst_dat2", dat2, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Routing
      dat1_ready = 1'b1; dat2_ready = 1'b1;
      in_valid = 1'b1; port_select = 1'b0; data_in = 32'd123;
      cyc();
      port_select = 1'b1; data_in = 32'd987;
      chk("route_dat1", dat1, 32'd123);
      chk("route_dat1_valid", 32'(dat1_valid), 32'd1);
      chk("route_dat2_valid_early", 32'(dat2_valid), 32'd0);
      cyc();
      in_valid = 1'b0;
      chk("route_dat1_valid_once", 32'(dat1_valid), 32'd0);
      chk("route_dat2", dat2, 32'd987);
      chk("route_dat2_valid", 32'(dat2_valid), 32'd1);
      cyc();
      chk("route_dat2_valid_once", 32'(dat2_valid), 32'd0);
      chk("route_dat1_hold", dat1, 32'd123);

      // Backpressure on port 1
      dat1_ready = 1'b0;
      push_word(1'b0, 32'd445); push_word(1'b0, 32'd222);
      push_word(1'b0, 32'd7);   push_word(1'b0, 32'd9);
      port_select = 1'b0;
      chk("bp_count1", 32'(count1), 32'd4);
      chk("bp_in_ready_sel0", 32'(in_ready), 32'd0);
      chk("bp_dat1_head", dat1, 32'd445);
      port_select = 1'b1;
      #1;
      chk("bp_in_ready_sel1", 32'(in_ready), 32'd1);
      push_word(1'b1, 32'd5);
      chk("bp_dat2", dat2, 32'd5);
      dat1_ready = 1'b1;
      chk("bp_out0", dat1, 32'd445); cyc();
      chk("bp_out1", dat1, 32'd222); cyc();
      chk("bp_out2", dat1, 32'd7);   cyc();
      chk("bp_out3", dat1, 32'd9);   cyc();
      chk("bp_drained", 32'(dat1_valid), 32'd0);

      // Full push+pop on port 1
      dat1_ready = 1'b0;
      push_word(1'b0, 32'd1); push_word(1'b0, 32'd2);
      push_word(1'b0, 32'd3); push_word(1'b0, 32'd4);
      dat1_ready = 1'b1; in_valid = 1'b1; port_select = 1'b0; data_in = 32'd100;
      #1;
      chk("full_in_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("full_pop_only_count", 32'(count1), 32'd3);
      chk("full_in_ready_rise", 32'(in_ready), 32'd1);
      chk("full_head_after_pop", dat1, 32'd2);
      cyc();
      in_valid = 1'b0;
      chk("full_pushpop_count", 32'(count1), 32'd3);
      chk("full_head_after_pushpop", dat1, 32'd3);
      cyc(); cyc();
      chk("full_tail", dat1, 32'd100);
      cyc();

      // Empty push+pop on port 2
      dat2_ready = 1'b1; port_select = 1'b1;
      chk("empty_count2_before", 32'(count2), 32'd0);
      push_word(1'b1, 32'd11);
      chk("empty_count2", 32'(count2), 32'd1);
      chk("empty_dat2", dat2, 32'd11);
      cyc();

      // Mixed traffic checked by the model only
      for (int i = 0; i < 200; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         port_select = 1'($urandom_range(0, 1));
         data_in     = $urandom;
         dat1_ready  = ($urandom_range(0, 3) != 0);
         dat2_ready  = ($urandom_range(0, 2) == 0);
`ifdef DEMUX_STATS_EN
         stats_clr   = ($urandom_range(0, 31) == 0);
`endif
         cyc();
      end
      in_valid = 1'b0;
`ifdef DEMUX_STATS_EN
      stats_clr = 1'b0;
`endif
      dat1_ready = 1'b1; dat2_ready = 1'b1;
      repeat (DEPTH + 1) cyc();

      // Reset mid-operation with two words in each FIFO
      dat1_ready = 1'b0; dat2_ready = 1'b0;
      push_word(1'b0, 32'd21); push_word(1'b0, 32'd22);
      push_word(1'b1, 32'd31); push_word(1'b1, 32'd32);
      chk("mid_count1_pre", 32'(count1), 32'd2);
      chk("mid_count2_pre", 32'(count2), 32'd2);
      rst = 1'b1; in_valid = 1'b1; port_select = 1'b0; data_in = 32'd99; dat1_ready = 1'b1;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      chk("mid_count1", 32'(count1), 32'd0);
      chk("mid_count2", 32'(count2), 32'd0);
      chk("mid_valid1", 32'(dat1_valid), 32'd0);
      chk("mid_valid2", 32'(dat2_valid), 32'd0);
      chk("mid_dat1", dat1, 32'd0);
      chk("mid_dat2", dat2, 32'd0);
`ifdef DEMUX_STATS_EN
      chk("mid_xfer1", 32'(xfer1_cnt), 32'd0);
      chk("mid_xfer2", 32'(xfer2_cnt), 32'd0);
`endif
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
